// File: rtl/uart_midi_tx.sv
// MIDI UART transmitter: accepts one 1-3 byte MIDI event per valid/ready handshake and
// shifts it out as back-to-back 8N1 frames on tx_out. Running-status compression can
// drop a channel status byte that matches the last one sent.
//
// Ports:
//   clk_in        system clock (clk_98_3mhz domain)
//   rst_in        synchronous reset, active low
//   valid_in      event present on midi_event / num_bytes_in
//   midi_event    [23:16] status, [15:8] data1, [7:0] data2
//   num_bytes_in  bytes to send (0 = empty event)
//   ready_out     idle and able to accept an event
//   tx_out        UART line, idle high
//   busy_out      a frame is being shifted
//   done_out      one-cycle pulse after the last stop bit of an event
module uart_midi_tx #(
    parameter int unsigned CLKS_PER_BIT   = 3147,
    parameter int unsigned RUNNING_STATUS = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid_in,
    input  logic [23:0] midi_event,
    input  logic [1:0]  num_bytes_in,
    output logic        ready_out,
    output logic        tx_out,
    output logic        busy_out,
    output logic        done_out
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BaudMax = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e        state_q;
    logic [CW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [1:0]    byte_q;
    logic [1:0]    cnt_q;
    logic [23:0]   buf_q;     // bytes still to send after the current one, next at [23:16]
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          done_q;
    logic [7:0]    rs_status_q;
    logic          rs_valid_q;

    // Accept-time decode of the running-status decision.
    logic [7:0]  status;
    logic        is_chan;
    logic        is_sys;
    logic        skip;
    logic [23:0] load_bytes;
    logic [1:0]  load_cnt;
    logic        baud_wrap;

    always_comb begin
        status     = midi_event[23:16];
        is_chan    = (status >= 8'h80) && (status <= 8'hEF);
        is_sys     = (status >= 8'hF0) && (status <= 8'hF7);
        skip       = (RUNNING_STATUS != 0) && (num_bytes_in != 2'd0) && is_chan &&
                     rs_valid_q && (status == rs_status_q);
        load_bytes = skip ? {midi_event[15:0], 8'h00} : midi_event;
        load_cnt   = skip ? (num_bytes_in - 2'd1) : num_bytes_in;
        baud_wrap  = (baud_q == BaudMax);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= StIdle;
            baud_q      <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            cnt_q       <= '0;
            buf_q       <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
            rs_status_q <= '0;
            rs_valid_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (valid_in) begin
                        // Empty events leave the running status untouched.
                        if ((RUNNING_STATUS != 0) && (num_bytes_in != 2'd0)) begin
                            if (is_chan) begin
                                rs_status_q <= status;
                                rs_valid_q  <= 1'b1;
                            end else if (is_sys) begin
                                rs_valid_q  <= 1'b0;
                            end
                        end
                        if (load_cnt != 2'd0) begin
                            state_q <= StStart;
                            tx_q    <= 1'b0;
                            baud_q  <= '0;
                            byte_q  <= '0;
                            cnt_q   <= load_cnt;
                            shift_q <= load_bytes[23:16];
                            buf_q   <= {load_bytes[15:0], 8'h00};
                        end
                    end
                end
                StStart: begin
                    if (baud_wrap) begin
                        state_q <= StData;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                StData: begin
                    if (baud_wrap) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= StStop;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                StStop: begin
                    if (baud_wrap) begin
                        baud_q <= '0;
                        if ((byte_q + 2'd1) < cnt_q) begin
                            // Next byte starts with no idle gap.
                            state_q <= StStart;
                            byte_q  <= byte_q + 2'd1;
                            tx_q    <= 1'b0;
                            shift_q <= buf_q[23:16];
                            buf_q   <= {buf_q[15:0], 8'h00};
                        end else begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready_out = (state_q == StIdle);
    assign busy_out  = (state_q != StIdle);
    assign tx_out    = tx_q;
    assign done_out  = done_q;

endmodule
